// File: rtl/k_sorting_merge_if.sv
// k_sorting_merge_if: lane heads, pop strobes and result stream of the top-K merger; master = lanes/consumer side, slave = merger
interface k_sorting_merge_if #(
  parameter int NUM_LANES = 2,
  parameter int VAL_WIDTH = 32,
  parameter int K         = 4
);
  localparam int RW = $clog2(K) + 1;
  logic                           start;
  logic [32*NUM_LANES-1:0]        lane_name_in;
  logic [VAL_WIDTH*NUM_LANES-1:0] lane_value_in;
  logic [NUM_LANES-1:0]           lane_out_en;
  logic                           out_valid;
  logic                           out_ready;
  logic [31:0]                    out_name;
  logic [VAL_WIDTH-1:0]           out_value;
  logic [RW-1:0]                  out_rank;
  logic                           out_last;
  logic                           busy;
  logic                           merge_done;
  modport master (
    output start, lane_name_in, lane_value_in, out_ready,
    input  lane_out_en, out_valid, out_name, out_value, out_rank, out_last, busy, merge_done
  );
  modport slave (
    input  start, lane_name_in, lane_value_in, out_ready,
    output lane_out_en, out_valid, out_name, out_value, out_rank, out_last, busy, merge_done
  );
endinterface

// File: rtl/k_sorting_merge.sv
// k_sorting_merge: merges NUM_LANES ascending top-K lane lists into one ascending top-K valid/ready stream (ports: clk, reset, bus slave)
module k_sorting_merge #(
  parameter int NUM_LANES = 2,
  parameter int VAL_WIDTH = 32,
  parameter int K         = 4
) (
  input  logic             clk,
  input  logic             reset,
  k_sorting_merge_if.slave bus
);
  localparam int CW = $clog2(K) + 1;
  localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  typedef enum logic [1:0] {IDLE, MERGE, DONE} state_t;
  state_t               r_state, w_next;
  logic [CW-1:0]        r_cnt [NUM_LANES];
  logic [CW-1:0]        r_emitted;
  logic                 r_valid, r_last;
  logic [31:0]          r_name;
  logic [VAL_WIDTH-1:0] r_value;
  logic [CW-1:0]        r_rank;
  logic [LW-1:0]        w_win;
  logic                 w_found;
  logic [VAL_WIDTH-1:0] w_best;
  logic                 w_load, w_accept, w_clear;
  assign w_accept = r_valid && bus.out_ready;
  assign w_clear  = r_state != MERGE && bus.start;
  assign w_load   = r_state == MERGE && r_emitted < CW'(K) && (!r_valid || bus.out_ready) && w_found;
  always_comb begin
    w_next = r_state;
    if (r_state == MERGE) w_next = w_accept && r_last ? DONE : MERGE;
    else if (bus.start) w_next = MERGE;
  end
  // strict less-than keeps the lowest-index lane on ties
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_best  = '0;
    for (int l = 0; l < NUM_LANES; l++)
      if (r_cnt[l] != CW'(K) && (!w_found || bus.lane_value_in[VAL_WIDTH*l +: VAL_WIDTH] < w_best)) begin
        w_found = 1'b1;
        w_best  = bus.lane_value_in[VAL_WIDTH*l +: VAL_WIDTH];
        w_win   = LW'(l);
      end
  end
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++)
      r_cnt[l] <= reset || w_clear ? '0 : r_cnt[l] + CW'(w_load && w_win == LW'(l));
    r_emitted <= reset || w_clear ? '0 : r_emitted + CW'(w_load);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_name  <= '0;
      r_value <= '0;
      r_rank  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_last  <= r_emitted == CW'(K - 1);
      r_name  <= bus.lane_name_in[32*w_win +: 32];
      r_value <= w_best;
      r_rank  <= r_emitted;
    end else if (w_accept) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end
  assign bus.lane_out_en = w_load ? NUM_LANES'(1) << w_win : '0;
  assign bus.out_valid   = r_valid;
  assign bus.out_last    = r_last;
  assign bus.out_name    = r_name;
  assign bus.out_value   = r_value;
  assign bus.out_rank    = r_rank;
  assign bus.busy        = r_state == MERGE;
  assign bus.merge_done  = r_state == DONE;
endmodule
